bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_pkg.sv | 15 +
 rtl/bin2bcd_digit.sv | 9 +
 rtl/bin2bcd_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and sizing helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest digit count that the converter accepts for a W-bit operand.
  function automatic int min_nd(input int w);
    return (w + (w - 4) / 3 + 1 + 3) / 4;
  endfunction

endpackage

// File: rtl/bin2bcd_digit.sv
// One BCD digit correction step: add 3 (mod 16) when the digit exceeds 4.
module bin2bcd_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per clock, W cycles per operand.
// Define BIN2BCD_SEQ_SIGNED_EN to treat bin as two's complement and add out_sign.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*ND-1:0] bcd,
`ifdef BIN2BCD_SEQ_SIGNED_EN
  output logic            out_sign,
`endif
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its data stable until that edge.

  localparam int CW = $clog2(W + 1);
  localparam int RW = 4 * ND + W;

  if (W < 4 || W > 32) begin : g_bad_w
    $error("bin2bcd_seq: W=%0d outside legal range 4..32", W);
  end
  if (ND < min_nd(W)) begin : g_bad_nd
    $error("bin2bcd_seq: ND=%0d too small for W=%0d (need %0d)", ND, W, min_nd(W));
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   work;
  logic [RW-1:0]   shifted;
  logic [4*ND-1:0] corr;
  logic [W-1:0]    operand;

`ifdef BIN2BCD_SEQ_SIGNED_EN
  logic sign_p;

  // The most negative value negates to 2^(W-1), which still fits unsigned in W bits.
  assign operand = bin[W-1] ? (~bin + W'(1)) : bin;
`else
  assign operand = bin;
`endif

  for (genvar d = 0; d < ND; d++) begin : g_digit
    bin2bcd_digit u_digit (
      .din  (work[W + 4*d +: 4]),
      .dout (corr[4*d +: 4])
    );
  end

  // The top bit falls off; it is always zero for a legal digit count.
  assign shifted   = {corr, work[W-1:0]} << 1;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      bcd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
      sign_p    <= 1'b0;
      out_sign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= {{(4*ND){1'b0}}, operand};
            cnt      <= CW'(W);
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef BIN2BCD_SEQ_SIGNED_EN
            sign_p   <= bin[W-1];
`endif
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - CW'(1);
          // bcd only changes here, on the final shift, so it is never partial.
          if (cnt == CW'(1)) begin
            bcd       <= shifted[RW-1 -: 4*ND];
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef BIN2BCD_SEQ_SIGNED_EN
            out_sign  <= sign_p;
`endif
          end
        end
        DONE: begin
          if (out_ready && out_valid) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
